// File: rtl/anim_pkg.sv
// Shared types and constants for the goose-demo animation scheduler.
// Contents: FSM state enum, speed encodings, speed-to-period helper, background indices.
// Imported by anim_scheduler and btn_debounce.
package anim_pkg;

    typedef enum logic {
        PLAY   = 1'b0,
        PAUSED = 1'b1
    } state_t;

    // Speed select encodings (raw 2-bit input value)
    localparam logic [1:0] SPD_8  = 2'b00;
    localparam logic [1:0] SPD_4  = 2'b01;
    localparam logic [1:0] SPD_16 = 2'b10;
    localparam logic [1:0] SPD_2  = 2'b11;

    localparam int PKG_DIV_BITS = 4;

    // Background select indices
    localparam logic [1:0] BG_GRASS = 2'd0;
    localparam logic [1:0] BG_UW    = 2'd1;
    localparam logic [1:0] BG_BLUE  = 2'd2;
    localparam logic [1:0] BG_GREEN = 2'd3;

    // Returns the terminal divider count (period minus one) for a speed code.
    function automatic logic [PKG_DIV_BITS-1:0] speed_to_period(input logic [1:0] spd);
        logic [PKG_DIV_BITS-1:0] p;
        case (spd)
            SPD_8:   p = 4'd7;
            SPD_4:   p = 4'd3;
            SPD_16:  p = 4'd15;
            default: p = 4'd1;   // SPD_2
        endcase
        return p;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Frame-qualified button debouncer: 2-FF synchroniser plus stability counter.
// Ports: clk, rst_n, frame_start, btn_raw in; level (debounced), rise (1-cycle, aligned to frame_start) out.
// Latency: 2 cycles sync + DEBOUNCE_FRAMES stable frame_start samples; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic frame_start,
    input  logic btn_raw,
    output logic level,
    output logic rise
);
    import anim_pkg::*;

    logic       btn_s1, btn_s2;
    logic [3:0] cnt;
    logic [3:0] cnt_inc;
    logic       hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            btn_s1 <= btn_raw;
            btn_s2 <= btn_s1;
        end
    end

    assign cnt_inc = cnt + 4'd1;
    // The level flips on the sample that would bring the count to the threshold.
    assign hit     = frame_start && (btn_s2 != level) && (cnt_inc == 4'(DEBOUNCE_FRAMES));
    assign rise    = hit && btn_s2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 4'd0;
            level <= 1'b0;
        end else if (frame_start) begin
            if (btn_s2 == level) begin
                cnt <= 4'd0;
            end else if (hit) begin
                cnt   <= 4'd0;
                level <= btn_s2;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end

endmodule

// File: rtl/anim_scheduler.sv
// Animation frame / background sequencer for the VGA goose demo; all updates land on frame_start.
// Ports: clk, rst_n, frame_start, pause, speed, btn_bg in; frame_num, bg_sel, step_pulse, frame_counter, paused out.
// Latency: outputs registered one cycle after the frame_start cycle; raw inputs see 2-FF sync. Macro ANIM_PINGPONG_EN selects ping-pong sequencing.
module anim_scheduler #(
    parameter int FRAME_BITS      = 2,
    parameter int DIV_BITS        = 4,
    parameter int DEBOUNCE_FRAMES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  pause,
    input  logic [1:0]            speed,
    input  logic                  btn_bg,
    output logic [FRAME_BITS-1:0] frame_num,
    output logic [1:0]            bg_sel,
    output logic                  step_pulse,
    output logic [6:0]            frame_counter,
    output logic                  paused
);
    import anim_pkg::*;

    logic                  pause_s1, pause_s2;
    logic [1:0]            speed_s1, speed_s2;
    state_t                state, state_nxt;
    logic [DIV_BITS-1:0]   div, div_nxt, period_m1;
    logic [FRAME_BITS-1:0] fn_nxt;
    logic                  step_nxt;
    logic                  bg_level;
    logic                  bg_rise;

`ifdef ANIM_PINGPONG_EN
    localparam logic [FRAME_BITS-1:0] FN_MAX = {FRAME_BITS{1'b1}};
    logic                  dir, dir_nxt;   // 0 = counting up
    logic [FRAME_BITS-1:0] fn_step;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_s1 <= 1'b0;
            pause_s2 <= 1'b0;
            speed_s1 <= 2'b00;
            speed_s2 <= 2'b00;
        end else begin
            pause_s1 <= pause;
            pause_s2 <= pause_s1;
            speed_s1 <= speed;
            speed_s2 <= speed_s1;
        end
    end

    btn_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_btn (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_start(frame_start),
        .btn_raw    (btn_bg),
        .level      (bg_level),
        .rise       (bg_rise)
    );

    assign period_m1 = DIV_BITS'(speed_to_period(speed_s2));

    always_comb begin
        state_nxt = state;
        div_nxt   = div;
        fn_nxt    = frame_num;
        step_nxt  = 1'b0;
`ifdef ANIM_PINGPONG_EN
        dir_nxt   = dir;
        fn_step   = dir ? (frame_num - FRAME_BITS'(1)) : (frame_num + FRAME_BITS'(1));
`endif
        if (frame_start) begin
            case (state)
                PLAY:    if (pause_s2)  state_nxt = PAUSED;
                PAUSED:  if (!pause_s2) state_nxt = PLAY;
                default: state_nxt = PLAY;
            endcase
            // The divider runs exactly when the frame ends up in PLAY: a pause
            // request freezes it on its entry frame, a release resumes it at once.
            if (!pause_s2) begin
                // >= so a shortened period takes effect without a long wrap.
                if (div >= period_m1) begin
                    div_nxt  = '0;
                    step_nxt = 1'b1;
`ifdef ANIM_PINGPONG_EN
                    fn_nxt = fn_step;
                    if (fn_step == FN_MAX) begin
                        dir_nxt = 1'b1;
                    end else if (fn_step == '0) begin
                        dir_nxt = 1'b0;
                    end
`else
                    fn_nxt = frame_num + FRAME_BITS'(1);
`endif
                end else begin
                    div_nxt = div + DIV_BITS'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= PLAY;
            div           <= '0;
            frame_num     <= '0;
            step_pulse    <= 1'b0;
            paused        <= 1'b0;
            frame_counter <= 7'd0;
            bg_sel        <= BG_GRASS;
        end else begin
            state      <= state_nxt;
            div        <= div_nxt;
            frame_num  <= fn_nxt;
            step_pulse <= step_nxt;
            paused     <= (state_nxt == PAUSED);
            if (frame_start) begin
                frame_counter <= frame_counter + 7'd1;
            end
            if (bg_rise) begin
                bg_sel <= bg_sel + 2'd1;
            end
        end
    end

`ifdef ANIM_PINGPONG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir <= 1'b0;
        end else begin
            dir <= dir_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_anim_scheduler.sv
module tb_anim_scheduler;

    logic       clk;
    logic       rst_n;
    logic       frame_start;
    logic       pause;
    logic [1:0] speed;
    logic       btn_bg;
    logic [1:0] frame_num;
    logic [1:0] bg_sel;
    logic       step_pulse;
    logic [6:0] frame_counter;
    logic       paused;

    anim_scheduler #(
        .FRAME_BITS(2),
        .DIV_BITS(4),
        .DEBOUNCE_FRAMES(4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .pause        (pause),
        .speed        (speed),
        .btn_bg       (btn_bg),
        .frame_num    (frame_num),
        .bg_sel       (bg_sel),
        .step_pulse   (step_pulse),
        .frame_counter(frame_counter),
        .paused       (paused)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] fn;
        logic [6:0] cnt;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   fc    = 0;    // frames issued since last reset
    int   sidx  = 0;    // steps expected since last reset
    int   steps_seen = 0;

    // Expected frame index after the k-th step since reset.
    function automatic int exp_fn(input int k);
`ifdef ANIM_PINGPONG_EN
        case (k % 6)
            0: return 0;
            1: return 1;
            2: return 2;
            3: return 3;
            4: return 2;
            default: return 1;
        endcase
`else
        return k % 4;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One video frame; pushes the expected step event first when one is due.
    task automatic frame(input bit exp_step);
        exp_t e;
        if (exp_step) begin
            sidx++;
            e.fn  = 2'(exp_fn(sidx));
            e.cnt = 7'((fc + 1) % 128);
            q.push_back(e);
        end
        repeat (4) @(negedge clk);
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        fc++;
    endtask

    // Monitor: every step_pulse must match the oldest expected step.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && step_pulse === 1'b1) begin
            steps_seen++;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_step: got frame_num=%0d cnt=%0d expected no step", frame_num, frame_counter);
            end else begin
                e = q.pop_front();
                if (frame_num !== e.fn || frame_counter !== e.cnt) begin
                    bad++;
                    $display("FAIL step_event: got frame_num=%0d cnt=%0d expected frame_num=%0d cnt=%0d",
                             frame_num, frame_counter, e.fn, e.cnt);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; pause = 1'b0; speed = 2'b00; btn_bg = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_frame_num", frame_num, 0);
        chk("rst_bg_sel", bg_sel, 0);
        chk("rst_step", step_pulse, 0);
        chk("rst_counter", frame_counter, 0);
        chk("rst_paused", paused, 0);
        rst_n = 1'b1;

        // Default speed, period 8: steps at frames 8,16,24,32,40
        for (int f = 1; f <= 40; f++) frame(f % 8 == 0);
        repeat (2) @(negedge clk);
        chk("t1_steps", steps_seen, 5);
        chk("t1_counter", frame_counter, 40);
        chk("t1_frame_num", frame_num, exp_fn(5));

        // Period 2 for 6 frames, one more to leave div=1, then period 16
        speed = 2'b11;
        for (int i = 1; i <= 6; i++) frame(i % 2 == 0);
        frame(0);
        speed = 2'b10;
        for (int i = 1; i <= 15; i++) begin
            frame(i == 15);
            if (i == 14) chk("t2_no_early_step", frame_num, exp_fn(8));
        end
        chk("t2_frame_num", frame_num, exp_fn(9));

        // Pause with div=5 held for 20 frames, then resume from held value
        speed = 2'b00;
        for (int i = 1; i <= 5; i++) frame(0);
        pause = 1'b1;
        for (int i = 1; i <= 20; i++) frame(0);
        chk("t3_paused", paused, 1);
        chk("t3_frame_hold", frame_num, exp_fn(9));
        chk("t3_counter", frame_counter, 87);
        pause = 1'b0;
        frame(0);
        chk("t3_unpaused", paused, 0);
        frame(0);
        frame(1);
        // Pause in the same frame as a terminal count suppresses the step
        for (int i = 1; i <= 7; i++) frame(0);
        pause = 1'b1;
        frame(0);
        chk("t3_pause_at_terminal", paused, 1);
        pause = 1'b0;
        frame(1);

        // Button debounce while paused: bounce 1,0,1 then held high
        pause = 1'b1;
        btn_bg = 1'b1; frame(0);
        btn_bg = 1'b0; frame(0);
        btn_bg = 1'b1; frame(0);
        frame(0); frame(0);
        chk("t4_bg_not_yet", bg_sel, 0);
        frame(0);
        chk("t4_bg_first", bg_sel, 1);
        frame(0);
        btn_bg = 1'b0;
        for (int i = 1; i <= 4; i++) frame(0);
        chk("t4_bg_release", bg_sel, 1);
        for (int p = 1; p <= 5; p++) begin
            btn_bg = 1'b1;
            for (int i = 1; i <= 4; i++) frame(0);
            btn_bg = 1'b0;
            for (int i = 1; i <= 4; i++) frame(0);
        end
        chk("t4_bg_wrap", bg_sel, 2);
        chk("t4_counter_wrap", frame_counter, 22);
        chk("t4_frame_num", frame_num, exp_fn(11));

        // Asynchronous reset mid-frame
        pause = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_frame_num", frame_num, 0);
        chk("ar_bg_sel", bg_sel, 0);
        chk("ar_step", step_pulse, 0);
        chk("ar_counter", frame_counter, 0);
        chk("ar_paused", paused, 0);
        chk("ar_pending", q.size(), 0);
        q.delete();
        sidx = 0;
        fc   = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Restart at period 8, then period 2 walks the frame sequence
        for (int f = 1; f <= 16; f++) frame(f % 8 == 0);
        speed = 2'b11;
        for (int i = 1; i <= 16; i++) frame(i % 2 == 0);
        repeat (3) @(negedge clk);
        chk("t6_frame_num", frame_num, exp_fn(10));
        chk("t6_counter", frame_counter, 32);
        chk("end_pending", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
